// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and default constants for the MIPS program
// counter sequencer (pc_sequencer) and its next-PC selector (pc_next_mux).
//   pc_state_e : sequencer FSM states (BOOT, RUN, HALT), 2-bit encoding.
//   npc_sel_e  : which source feeds the PC register on the next edge.
//   PC_RESET_ADDR_DEF / PC_EXC_VECTOR_DEF : default reset and exception addresses.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        SEQ    = 3'd1,
        BRANCH = 3'd2,
        JUMP   = 3'd3,
        EXC    = 3'd4,
        ERET   = 3'd5
    } npc_sel_e;

    localparam logic [31:0] PC_RESET_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR_DEF = 32'h0000_0080;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: purely combinational next-PC selection for pc_sequencer.
// Applies the priority exc > halt > eret > stall > jump > branch > sequential
// in RUN; in HALT only an exception redirects; BOOT always holds.
// Ports:
//   state                        current sequencer state
//   exc, halt, eret, stall       control requests (eret tied low when unused)
//   jump, jump_target            jump request and destination
//   branch_taken, branch_target  branch request and destination
//   pc, epc                      current PC and saved exception PC
//   sel                          chosen next-PC source
//   npc                          next PC value
//   pc_plus                      pc + INSTR_BYTES (wraps modulo 2**WIDTH)
//   target_misaligned            low alignment bits of the selected redirect were nonzero
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          INSTR_BYTES = 4,
    parameter logic [31:0] EXC_VECTOR  = PC_EXC_VECTOR_DEF
) (
    input  pc_state_e        state,
    input  logic             exc,
    input  logic             halt,
    input  logic             eret,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] epc,
    output npc_sel_e         sel,
    output logic [WIDTH-1:0] npc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             target_misaligned
);

    localparam logic [WIDTH-1:0] STEP     = WIDTH'(INSTR_BYTES);
    // Mask form keeps INSTR_BYTES == 1 legal (no zero-width slice).
    localparam logic [WIDTH-1:0] LOW_MASK = STEP - WIDTH'(1);
    localparam logic [WIDTH-1:0] EXC_ADDR = WIDTH'(EXC_VECTOR);

    assign pc_plus = pc + STEP;

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        sel = HOLD;
        case (state)
            RUN: begin
                if (exc)               sel = EXC;
                else if (halt)         sel = HOLD;
                else if (eret)         sel = ERET;
                else if (stall)        sel = HOLD;  // concurrent redirect is dropped
                else if (jump)         sel = JUMP;
                else if (branch_taken) sel = BRANCH;
                else                   sel = SEQ;
            end
            HALT: begin
                if (exc) sel = EXC;
            end
            default: sel = HOLD;
        endcase
    end

    always_comb begin
        npc = pc;
        case (sel)
            SEQ:     npc = pc_plus;
            BRANCH:  npc = branch_target & ~LOW_MASK;
            JUMP:    npc = jump_target & ~LOW_MASK;
            EXC:     npc = EXC_ADDR;
            ERET:    npc = epc;
            default: npc = pc;
        endcase
    end

    // Only meaningful when sel is JUMP or BRANCH; the register ignores it otherwise.
    assign target_misaligned = (sel == JUMP) ? |(jump_target & LOW_MASK)
                                             : |(branch_target & LOW_MASK);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter for the MIPS fetch stage. Owns the PC
// register, the BOOT/RUN/HALT FSM and the misaligned-redirect flag.
// Optional macro PC_SEQ_EPC_EN adds exception return (eret in, epc out).
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 hold PC (hazard unit)
//   halt, resume          enter / leave HALT
//   branch_taken/_target  branch redirect
//   jump/jump_target      jump redirect (J/JAL/JR)
//   exc                   exception request, loads EXC_VECTOR
//   eret, epc             (PC_SEQ_EPC_EN only) return from exception, saved PC
//   pc_out                current fetch address
//   pc_plus               pc_out + INSTR_BYTES (link value)
//   fetch_valid           pc_out is a real fetch this cycle
//   misaligned            last loaded jump/branch target had nonzero low bits
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_ADDR  = PC_RESET_ADDR_DEF,
    parameter int          INSTR_BYTES = 4,
    parameter logic [31:0] EXC_VECTOR  = PC_EXC_VECTOR_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc,
`ifdef PC_SEQ_EPC_EN
    input  logic             eret,
    output logic [WIDTH-1:0] epc,
`endif
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic             fetch_valid,
    output logic             misaligned
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_ADDR);

    pc_state_e        state, next_state;
    npc_sel_e         sel;
    logic [WIDTH-1:0] npc;
    logic             target_misaligned;

`ifndef PC_SEQ_EPC_EN
    logic             eret;
    logic [WIDTH-1:0] epc;
    assign eret = 1'b0;
    assign epc  = '0;
`endif

    pc_next_mux #(
        .WIDTH       (WIDTH),
        .INSTR_BYTES (INSTR_BYTES),
        .EXC_VECTOR  (EXC_VECTOR)
    ) u_next_mux (
        .state             (state),
        .exc               (exc),
        .halt              (halt),
        .eret              (eret),
        .stall             (stall),
        .jump              (jump),
        .jump_target       (jump_target),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .pc                (pc_out),
        .epc               (epc),
        .sel               (sel),
        .npc               (npc),
        .pc_plus           (pc_plus),
        .target_misaligned (target_misaligned)
    );

    always_comb begin
        next_state  = state;
        fetch_valid = 1'b0;
        case (state)
            BOOT: next_state = RUN;
            RUN: begin
                fetch_valid = 1'b1;
                if (!exc && halt) next_state = HALT;
            end
            HALT: begin
                // resume wins over a still-asserted halt
                if (exc || resume) next_state = RUN;
            end
            default: next_state = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            pc_out     <= RST_PC;
            misaligned <= 1'b0;
        end else begin
            state  <= next_state;
            pc_out <= npc;
            if (sel == JUMP || sel == BRANCH) misaligned <= target_misaligned;
        end
    end

`ifdef PC_SEQ_EPC_EN
    // Captures the address current at the exception, including a stalled one.
    always_ff @(posedge clk) begin
        if (reset)          epc <= '0;
        else if (sel == EXC) epc <= pc_out;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer (WIDTH=32, INSTR_BYTES=4).
// Directed scenarios followed by randomized stimulus, all compared every cycle
// against a behavioural model. Define PC_SEQ_EPC_EN to also exercise eret/epc.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, halt, resume, branch_taken, jump, exc, eret;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, pc_plus;
    logic        fetch_valid, misaligned;
`ifdef PC_SEQ_EPC_EN
    logic [31:0] epc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model
    logic [31:0] m_pc, m_epc;
    logic        m_booting, m_halted, m_mis;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .halt          (halt),
        .resume        (resume),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc           (exc),
`ifdef PC_SEQ_EPC_EN
        .eret          (eret),
        .epc           (epc),
`endif
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .fetch_valid   (fetch_valid),
        .misaligned    (misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // One clock edge of the architectural behaviour, from the rules directly.
    task automatic model_step();
        logic do_eret;
`ifdef PC_SEQ_EPC_EN
        do_eret = eret;
`else
        do_eret = 1'b0;
`endif
        if (reset) begin
            m_pc = 32'h0; m_booting = 1'b1; m_halted = 1'b0; m_mis = 1'b0; m_epc = 32'h0;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            if (exc) begin
                m_epc = m_pc; m_pc = 32'h80; m_halted = 1'b0;
            end else if (resume) begin
                m_halted = 1'b0;
            end
        end else begin
            if (exc) begin
                m_epc = m_pc; m_pc = 32'h80;
            end else if (halt) begin
                m_halted = 1'b1;
            end else if (do_eret) begin
                m_pc = m_epc;
            end else if (stall) begin
                // hold, redirect lost
            end else if (jump) begin
                m_mis = (jump_target % 4) != 0;
                m_pc  = jump_target - (jump_target % 4);
            end else if (branch_taken) begin
                m_mis = (branch_target % 4) != 0;
                m_pc  = branch_target - (branch_target % 4);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pc_out", pc_out, m_pc);
        check("pc_plus", pc_plus, m_pc + 32'd4);
        check("fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_booting && !m_halted});
        check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
`ifdef PC_SEQ_EPC_EN
        check("epc", epc, m_epc);
`endif
    endtask

    task automatic clear_inputs();
        reset = 1'b0; stall = 1'b0; halt = 1'b0; resume = 1'b0; exc = 1'b0; eret = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        // first cycle after reset: BOOT
        check("boot_fv", {31'd0, fetch_valid}, 32'd0);
        check("boot_pc", pc_out, 32'h0);
        cycle(); check("run_pc0", pc_out, 32'h0); check("run_fv", {31'd0, fetch_valid}, 32'd1);
        cycle(); check("run_pc4", pc_out, 32'h4);
        cycle(); check("run_pc8", pc_out, 32'h8);
        cycle(); cycle(); check("pre_stall_pc", pc_out, 32'h10);

        // stall with a branch presented: branch dropped
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        repeat (3) begin
            cycle(); check("stall_hold", pc_out, 32'h10);
        end
        stall = 1'b0; branch_taken = 1'b0;
        cycle(); check("stall_release", pc_out, 32'h14);

        // jump beats branch, then misaligned jump
        jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
        cycle(); check("jump_wins", pc_out, 32'h200); check("mis_clear", {31'd0, misaligned}, 32'd0);
        branch_taken = 1'b0; jump_target = 32'h103;
        cycle(); check("jump_align", pc_out, 32'h100); check("mis_set", {31'd0, misaligned}, 32'd1);

        // address wrap
        jump_target = 32'hFFFF_FFFC;
        cycle(); check("wrap_plus", pc_plus, 32'h0);
        jump = 1'b0;
        cycle(); check("wrap_pc", pc_out, 32'h0);

        // halt then exception in HALT
        jump = 1'b1; jump_target = 32'h20;
        cycle(); jump = 1'b0; halt = 1'b1;
        cycle(); check("halt_pc", pc_out, 32'h20); check("halt_fv", {31'd0, fetch_valid}, 32'd0);
        halt = 1'b0; exc = 1'b1;
        cycle(); check("halt_exc_pc", pc_out, 32'h80); check("halt_exc_fv", {31'd0, fetch_valid}, 32'd1);
        exc = 1'b0;

        // halt and resume together in HALT
        jump = 1'b1; jump_target = 32'h20;
        cycle(); jump = 1'b0; halt = 1'b1;
        cycle(); resume = 1'b1;
        cycle(); check("resume_pc", pc_out, 32'h20); check("resume_fv", {31'd0, fetch_valid}, 32'd1);
        resume = 1'b0;

        // reset mid-HALT
        cycle(); halt = 1'b0; reset = 1'b1;
        cycle(); check("rst_halt_pc", pc_out, 32'h0); check("rst_halt_fv", {31'd0, fetch_valid}, 32'd0);
        reset = 1'b0;
        cycle(); cycle(); check("post_rst_pc", pc_out, 32'h4);

        // reset mid-stall with a pending jump
        stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
        cycle(); reset = 1'b1;
        cycle(); check("rst_stall_pc", pc_out, 32'h0); check("rst_stall_fv", {31'd0, fetch_valid}, 32'd0);
        clear_inputs();
        cycle();

`ifdef PC_SEQ_EPC_EN
        jump = 1'b1; jump_target = 32'h44;
        cycle(); jump = 1'b0; exc = 1'b1;
        cycle(); check("epc_capture", epc, 32'h44); check("exc_pc", pc_out, 32'h80);
        exc = 1'b0; eret = 1'b1;
        cycle(); check("eret_pc", pc_out, 32'h44);
        eret = 1'b0;
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(99) == 0);
            stall         = ($urandom_range(3) == 0);
            halt          = ($urandom_range(15) == 0);
            resume        = ($urandom_range(3) == 0);
            exc           = ($urandom_range(31) == 0);
            eret          = ($urandom_range(15) == 0);
            jump          = ($urandom_range(7) == 0);
            branch_taken  = ($urandom_range(5) == 0);
            jump_target   = $urandom;
            branch_target = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
